vram_line_prefetch: RTL

- Sits between the shared video RAM port and the video raster block.
- Serves the raster's 14-bit vram_addr reads from two 32-word line buffers (front and back).
- Fetches each scanline's 32 words ahead of time over a req/ack memory handshake, so the raster never waits on memory arbitration.
- Output vram_data feeds the raster's vram_data input directly.

---
 rtl/vram_line_prefetch.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_line_prefetch.sv
// vram_line_prefetch: double-buffered scanline cache between the shared VRAM
// port and the raster. The raster reads from the front line buffer with one
// cycle of latency. A req/ack fetch engine fills the back buffer with the
// next scanline ahead of time, or with a missed line on demand.
// Optional feature: define VRAM_PREFETCH_SNOOP_EN so that CPU writes on the
// snoop port update resident or in-flight lines. Without the macro the snoop
// ports are present but ignored.
module vram_line_prefetch #(
    parameter int ADDR_W = 14,
    parameter int ROW_W  = 8
) (
    input  logic              clk_pix,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] vram_addr,
    output logic [15:0]       vram_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_din,
    output logic              busy,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic [15:0]       snoop_data
);

    localparam int TAG_W = ADDR_W - 5;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL} state_t;

    // The two physical buffers. sel_q selects which one is the front buffer.
    logic [15:0]      buf_q [2][32];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       valid_q;
    logic             sel_q;

    state_t           state_q;
    logic [4:0]       cnt_q;
    logic [TAG_W-1:0] target_q;
    logic             restart_q;
    logic [TAG_W-1:0] restart_tag_q;
    logic             mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic             busy_q;
    logic [15:0]      vram_data_q;

    logic [TAG_W-1:0] rd_tag;
    logic [4:0]       rd_word;
    logic             front_idx;
    logic             back_idx;
    logic             hit_front;
    logic             hit_back;
    logic             miss;
    logic [TAG_W-1:0] next_tag;
    logic             new_miss_d;
    logic             restart_d;
    logic [TAG_W-1:0] restart_tag_d;

    assign rd_tag    = vram_addr[ADDR_W-1:5];
    assign rd_word   = vram_addr[4:0];
    assign front_idx = sel_q;
    assign back_idx  = ~sel_q;
    assign hit_front = valid_q[front_idx] && (tag_q[front_idx] == rd_tag);
    assign hit_back  = !hit_front && valid_q[back_idx] && (tag_q[back_idx] == rd_tag);
    assign miss      = !hit_front && !hit_back;

    // Next scanline: the row wraps inside its own bits, the bank bit is kept.
    assign next_tag = {tag_q[front_idx][TAG_W-1:ROW_W],
                       tag_q[front_idx][ROW_W-1:0] + ROW_W'(1)};

    // A miss on a line other than the one being fetched redirects the engine.
    assign new_miss_d    = miss && (rd_tag != target_q);
    assign restart_d     = restart_q || new_miss_d;
    assign restart_tag_d = new_miss_d ? rd_tag : restart_tag_q;

    assign vram_data = vram_data_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;

`ifdef VRAM_PREFETCH_SNOOP_EN
    logic [1:0] snoop_hit;

    // A CPU write lands in every valid line with a matching tag, and in the
    // back buffer while it is being filled for that tag.
    always_comb begin
        snoop_hit = '0;
        for (int i = 0; i < 2; i++) begin
            snoop_hit[i] = snoop_we &&
                ((valid_q[i] && (tag_q[i] == snoop_addr[ADDR_W-1:5])) ||
                 ((state_q != S_IDLE) && (1'(i) == back_idx) &&
                  (target_q == snoop_addr[ADDR_W-1:5])));
        end
    end
`else
    logic snoop_unused;
    assign snoop_unused = ^{snoop_we, snoop_addr, snoop_data};
`endif

    // Line buffer storage: fetched words go to the back buffer; snoop writes come
    // last so they win over a fetch of the same word in the same cycle.
    always_ff @(posedge clk_pix) begin
        if ((state_q == S_REQ) && mem_ack) begin
            buf_q[back_idx][cnt_q] <= mem_din;
        end
`ifdef VRAM_PREFETCH_SNOOP_EN
        for (int i = 0; i < 2; i++) begin
            if (snoop_hit[i]) begin
                buf_q[i][snoop_addr[4:0]] <= snoop_data;
            end
        end
`endif
    end

    // Registered read port: front hit, back hit (served while swapping), or zero.
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            vram_data_q <= 16'h0000;
        end else if (hit_front) begin
            vram_data_q <= buf_q[front_idx][rd_word];
        end else if (hit_back) begin
            vram_data_q <= buf_q[back_idx][rd_word];
        end else begin
            vram_data_q <= 16'h0000;
        end
    end

    // Fetch engine plus buffer bookkeeping (swap, tags, valid flags).
    always_ff @(posedge clk_pix or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 5'd0;
            target_q      <= '0;
            restart_q     <= 1'b0;
            restart_tag_q <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            busy_q        <= 1'b0;
            sel_q         <= 1'b0;
            valid_q       <= 2'b00;
            tag_q[0]      <= '0;
            tag_q[1]      <= '0;
        end else begin
            // Back hit: old back becomes front; old front is retired for refill.
            if (hit_back) begin
                sel_q              <= ~sel_q;
                valid_q[front_idx] <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (miss) begin
                        target_q          <= rd_tag;
                        cnt_q             <= 5'd0;
                        valid_q[back_idx] <= 1'b0;
                        restart_q         <= 1'b0;
                        mem_req_q         <= 1'b1;
                        mem_addr_q        <= {rd_tag, 5'd0};
                        busy_q            <= 1'b1;
                        state_q           <= S_REQ;
                    end else if (!valid_q[back_idx] && valid_q[front_idx]) begin
                        target_q          <= next_tag;
                        cnt_q             <= 5'd0;
                        valid_q[back_idx] <= 1'b0;
                        restart_q         <= 1'b0;
                        mem_req_q         <= 1'b1;
                        mem_addr_q        <= {next_tag, 5'd0};
                        busy_q            <= 1'b1;
                        state_q           <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (restart_d) begin
                            // Outstanding word done; restart on the missed line.
                            target_q   <= restart_tag_d;
                            cnt_q      <= 5'd0;
                            restart_q  <= 1'b0;
                            mem_addr_q <= {restart_tag_d, 5'd0};
                        end else if (cnt_q == 5'd31) begin
                            mem_req_q <= 1'b0;
                            state_q   <= S_FILL;
                        end else begin
                            cnt_q      <= cnt_q + 5'd1;
                            mem_addr_q <= {target_q, cnt_q + 5'd1};
                        end
                    end else if (new_miss_d) begin
                        restart_q     <= 1'b1;
                        restart_tag_q <= rd_tag;
                    end
                end
                S_FILL: begin
                    tag_q[back_idx]   <= target_q;
                    valid_q[back_idx] <= 1'b1;
                    busy_q            <= 1'b0;
                    state_q           <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule
